// File: rtl/fifo_uart_drain_pkg.sv
// fifo_uart_drain_pkg: shared FSM encoding and defaults for the FIFO-to-UART drain.
package fifo_uart_drain_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115200;
    localparam int WAIT_TIMEOUT = 3;

endpackage

// File: rtl/fifo_uart_drain_baud_cnt.sv
// baud_cnt: free-running bit-period counter, restarted by clr, ticking at terminal count.
module baud_cnt #(
    parameter int BAUD_DIV = 434
) (
    input  logic Clk,
    input  logic srst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(BAUD_DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(BAUD_DIV - 1);

    always_ff @(posedge Clk)
        cnt <= (srst || clr || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: reads bytes from a non-FWFT FIFO and sends each as an 8N1 UART frame.
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic       Clk,
    input  logic       srst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       uart_tx,
    output logic       busy,
    output logic       byte_done,
    output logic       rd_err
);

    state_t     state, state_nx;
    logic [7:0] shift;
    logic [2:0] idx;
    logic [1:0] tmo;
    logic       tick, clr, tx_nx, tmo_hit;

    baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .Clk (Clk),
        .srst(srst),
        .clr (clr),
        .tick(tick)
    );

    assign tmo_hit = state == WAIT && !fifo_valid && tmo == 2'(WAIT_TIMEOUT - 1);
    assign clr     = state_nx != state;

    always_ff @(posedge Clk)
        state <= srst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = fifo_rd_en ? WAIT : IDLE;
            WAIT:    state_nx = fifo_valid ? START : tmo_hit ? IDLE : WAIT;
            START:   state_nx = tick ? DATA : START;
            DATA:    state_nx = (tick && idx == 3'd7) ? STOP : DATA;
            STOP:    state_nx = tick ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    // Line level is computed from the next state so uart_tx can be a plain register.
    always_comb begin
        fifo_rd_en = state == IDLE && en && !fifo_empty && !srst;
        busy       = state != IDLE;
        tx_nx      = state_nx == START ? 1'b0 :
                     state_nx == DATA  ? ((state == DATA && tick) ? shift[1] : shift[0]) : 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (srst) begin
            shift     <= '0;
            idx       <= '0;
            tmo       <= '0;
            uart_tx   <= 1'b1;
            byte_done <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            if (state == WAIT && fifo_valid)
                shift <= fifo_dout;
            else if (state == DATA && tick)
                shift <= shift >> 1;
            idx       <= state == DATA ? idx + 3'(tick) : '0;
            tmo       <= state == WAIT ? tmo + 2'd1 : '0;
            uart_tx   <= tx_nx;
            byte_done <= state == STOP && tick;
            rd_err    <= rd_err | tmo_hit;
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb_fifo_uart_drain: directed bench with a behavioural byte FIFO feeding the drain.
module tb_fifo_uart_drain;

    logic       Clk = 1'b0;
    logic       srst = 1'b1;
    logic       en = 1'b1;
    logic       fifo_empty, fifo_valid = 1'b0, fifo_rd_en;
    logic [7:0] fifo_dout = '0;
    logic       uart_tx, busy, byte_done, rd_err;

    logic [7:0] q[$];
    bit         kill_valid = 1'b0;
    bit         underflow = 1'b0;
    int         cyc = 0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    fifo_uart_drain #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .Clk       (Clk),
        .srst      (srst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .byte_done (byte_done),
        .rd_err    (rd_err)
    );

    always #10 Clk = ~Clk;

    always_comb fifo_empty = q.size() == 0;

    // Standard-read FIFO: data and valid appear the cycle after rd_en; kill_valid acts as a dead stub.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        fifo_valid <= fifo_rd_en && !kill_valid && q.size() != 0;
        if (fifo_rd_en && !kill_valid) begin
            if (q.size() == 0) underflow <= 1'b1;
            else fifo_dout <= q.pop_front();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_rd(output bit ok);
        int n = 0;
        #1;
        while (!fifo_rd_en && n < 200) begin
            @(negedge Clk);
            #1;
            n++;
        end
        ok = fifo_rd_en;
    endtask

    task automatic rx_frame(output logic [7:0] b, output int t0, output bit ok);
        int n = 0;
        logic st, sp;
        ok = 1'b0;
        b  = '0;
        t0 = 0;
        @(negedge Clk);
        while (uart_tx && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (uart_tx) return;
        t0 = cyc;
        repeat (5) @(negedge Clk);
        st = uart_tx;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge Clk);
            b[i] = uart_tx;
        end
        repeat (10) @(negedge Clk);
        sp = uart_tx;
        ok = !st && sp;
    endtask

    initial begin
        bit         ok;
        int         bad, rds, dones, frames, badb, badp, t0, prev;
        logic [7:0] b, exp_b;
        logic [9:0] frame;

        // Reset held with data waiting and enable high.
        q.push_back(8'hA5);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (uart_tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || rd_err !== 1'b0 || byte_done !== 1'b0) bad++;
        end
        check("reset_outputs", bad, 0);
        check("reset_tx", uart_tx, 1);
        srst = 1'b0;

        // Single byte 0xA5: exact line waveform relative to the read cycle.
        wait_rd(ok);
        check("single_rd", ok, 1);
        frame = {1'b1, 8'hA5, 1'b0};
        bad = 0; rds = 0; dones = 0;
        for (int j = 1; j <= 110; j++) begin
            @(negedge Clk);
            if (j >= 2 && j <= 101 && uart_tx !== frame[(j - 2) / 10]) bad++;
            if ((j < 2 || j > 101) && uart_tx !== 1'b1) bad++;
            if (j == 102) check("single_done_at_idle", byte_done, 1);
            rds   += int'(fifo_rd_en);
            dones += int'(byte_done);
        end
        check("single_wave", bad, 0);
        check("single_extra_rd", rds, 0);
        check("single_done_cnt", dones, 1);
        check("single_busy_end", busy, 0);

        // Enable low with data present: no read.
        en = 1'b0;
        q.push_back(8'h3C);
        q.push_back(8'h81);
        rds = 0;
        repeat (30) begin
            @(negedge Clk);
            rds += int'(fifo_rd_en);
        end
        check("en_low_no_rd", rds, 0);

        // Enable dropped mid-DATA: frame finishes, no further read.
        en = 1'b1;
        wait_rd(ok);
        check("en_rd", ok, 1);
        rds = 0; dones = 0;
        for (int j = 1; j <= 150; j++) begin
            @(negedge Clk);
            if (j == 40) en = 1'b0;
            rds   += int'(fifo_rd_en);
            dones += int'(byte_done);
        end
        check("en_drop_no_rd", rds, 0);
        check("en_drop_done", dones, 1);
        check("en_drop_left", q.size(), 1);
        check("en_drop_idle", busy, 0);

        // Reset during DATA bit 3; the following byte must arrive intact.
        q.push_back(8'h5A);
        en = 1'b1;
        wait_rd(ok);
        check("rst_mid_rd", ok, 1);
        repeat (44) @(negedge Clk);
        check("rst_mid_tx_low", uart_tx, 1'b0);
        srst = 1'b1;
        @(negedge Clk);
        check("rst_mid_tx_high", uart_tx, 1);
        check("rst_mid_busy", busy, 0);
        srst = 1'b0;
        rx_frame(b, t0, ok);
        check("rst_mid_frame_ok", ok, 1);
        check("rst_mid_byte", b, 8'h5A);

        // Drain 250 words (low byte first) back-to-back.
        en = 1'b0;
        repeat (5) @(negedge Clk);
        for (int k = 0; k < 250; k++) begin
            q.push_back(8'(k));
            q.push_back(~8'(k));
        end
        en = 1'b1;
        frames = 0; badb = 0; badp = 0; prev = 0;
        for (int f = 0; f < 500; f++) begin
            rx_frame(b, t0, ok);
            if (!ok) break;
            exp_b = (f % 2 == 0) ? 8'(f / 2) : ~8'(f / 2);
            if (b !== exp_b) badb++;
            if (f > 0 && t0 - prev != 102) badp++;
            prev = t0;
            frames++;
        end
        repeat (20) @(negedge Clk);
        check("drain_frames", frames, 500);
        check("drain_bytes", badb, 0);
        check("drain_period", badp, 0);
        check("drain_underflow", underflow, 0);
        check("drain_empty", fifo_empty, 1);
        check("drain_busy", busy, 0);

        // Dead FIFO: valid never comes back.
        kill_valid = 1'b1;
        q.push_back(8'h77);
        wait_rd(ok);
        check("nv_rd", ok, 1);
        bad = 0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge Clk);
            if (uart_tx !== 1'b1) bad++;
            if (j == 3) check("nv_err_early", rd_err, 0);
            if (j == 4) begin
                check("nv_err", rd_err, 1);
                check("nv_idle", busy, 0);
            end
        end
        en = 1'b0;
        repeat (5) @(negedge Clk);
        check("nv_tx_high", bad, 0);
        check("nv_err_sticky", rd_err, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
